mac_accumulator_4bit: RTL and testbench

MAC_ACCUMULATOR_4BIT -- requirements
Module: mac_accumulator_4bit

---
 rtl/mac_accumulator_4bit.sv | 89 ++++++++
 tb/tb_mac_accumulator_4bit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mac_accumulator_4bit.sv
// Multiply-accumulate of 4-bit unsigned operand pairs into an ACC_W-bit sum.
// A result is presented when the last term arrives, and held until downstream consumes it.
//
// state | meaning
// ACCUM | accepting terms, running sum visible but not yet valid
// HOLD  | result valid, inputs blocked until out_ready
module mac_accumulator_4bit #(
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_overflow
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic           consume;
    logic [7:0]     product;
    logic [ACC_W:0] sum_ext;

    assign product = {4'b0000, a} * {4'b0000, b};
    assign sum_ext = {1'b0, out_sum} + {{(ACC_W - 7){1'b0}}, product};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        consume   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && in_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                consume   = out_ready;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_sum <= sum_ext[ACC_W-1:0];
                if (sum_ext[ACC_W]) begin
                    out_overflow <= 1'b1;
                end
                // count saturates rather than wrapping so long vectors still read as "many"
                if (out_count != 8'hFF) begin
                    out_count <= out_count + 8'd1;
                end
            end else if (consume) begin
                out_sum      <= '0;
                out_count    <= '0;
                out_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator_4bit.sv
// Bench for mac_accumulator_4bit: directed scenarios plus random traffic, every cycle
// compared against an unbounded-integer model of the dot product.
module tb_mac_accumulator_4bit;

    localparam int ACC_W = 12;
    localparam int MOD   = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    // model: true (unwrapped) total and term count of the current dot product
    bit m_hold  = 1'b0;
    int m_total = 0;
    int m_terms = 0;

    mac_accumulator_4bit #(.ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(!m_hold));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("out_sum", 32'(out_sum), 32'(m_total % MOD));
        chk("out_count", 32'(out_count), 32'((m_terms > 255) ? 255 : m_terms));
        chk("out_overflow", 32'(out_overflow), 32'(m_total >= MOD));
    endtask

    task automatic tick();
        bit acc;
        bit cons;
        acc  = !m_hold && in_valid;
        cons = m_hold && out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_hold  = 1'b0;
            m_total = 0;
            m_terms = 0;
        end else if (acc) begin
            m_total += int'(a) * int'(b);
            m_terms++;
            if (in_last) m_hold = 1'b1;
        end else if (cons) begin
            m_hold  = 1'b0;
            m_total = 0;
            m_terms = 0;
        end
        check_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb,
                         input logic last, input logic ordy, input logic r);
        in_valid  = v;
        a         = ta;
        b         = tb;
        in_last   = last;
        out_ready = ordy;
        rst       = r;
        tick();
    endtask

    initial begin
        in_valid = 0; a = 0; b = 0; in_last = 0; out_ready = 0; rst = 1;
        @(negedge clk);

        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_sum", 32'(out_sum), 32'd0);

        drive(1, 15, 15, 1, 0, 0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_sum", 32'(out_sum), 32'd225);
        chk("single_count", 32'(out_count), 32'd1);
        drive(0, 0, 0, 0, 1, 0);

        drive(1, 2, 3, 0, 0, 0);
        drive(1, 4, 5, 0, 0, 0);
        drive(1, 15, 15, 1, 0, 0);
        chk("dot_sum", 32'(out_sum), 32'd251);
        chk("dot_count", 32'(out_count), 32'd3);
        drive(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 19; i++) drive(1, 15, 15, 1'(i == 18), 0, 0);
        chk("ovf_sum", 32'(out_sum), 32'd179);
        chk("ovf_count", 32'(out_count), 32'd19);
        chk("ovf_flag", 32'(out_overflow), 32'd1);

        // held result with upstream pushing: nothing may be accepted
        for (int i = 0; i < 5; i++) drive(1, 9, 9, 1, 0, 0);
        chk("bp_sum", 32'(out_sum), 32'd179);
        chk("bp_ready", 32'(in_ready), 32'd0);
        drive(1, 9, 9, 1, 1, 0);
        chk("bp_cleared", 32'(out_sum), 32'd0);
        drive(1, 1, 1, 1, 0, 0);
        chk("bp_next_sum", 32'(out_sum), 32'd1);
        chk("bp_next_count", 32'(out_count), 32'd1);
        drive(0, 0, 0, 0, 1, 0);

        drive(1, 7, 7, 0, 0, 0);
        drive(1, 3, 3, 0, 0, 0);
        drive(1, 5, 5, 1, 1, 1);
        drive(1, 1, 1, 1, 0, 0);
        chk("mid_rst_sum", 32'(out_sum), 32'd1);
        chk("mid_rst_count", 32'(out_count), 32'd1);
        chk("mid_rst_ovf", 32'(out_overflow), 32'd0);
        drive(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 300; i++)
            drive(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'(i == 299), 0, 0);
        chk("sat_count", 32'(out_count), 32'd255);
        drive(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
